mul_result_collector: RTL and testbench
=======================================

// Module: mul_result_collector
// PURPOSE
// - Receiving end of the pipelined 4x4 multiplier's result stream.
// - Runs a session framed by sess_start and pipe_done.
// - Accepts result/res_vld into a FIFO and forwards products downstream on a valid/ready port.
// - Counts products and flags drops; asserts sess_done once the session's results have been drained.
// PARAMETERS
// - DATA_W  8   product width; matches the multiplier result
// - DEPTH   8   FIFO entries; power of 2, >=2
// - CNT_W   16  product counter width
// - SUM_W   16  accumulator width (only with the macro)
// PORTS
// - clk        in   1       rising-edge clock
// - reset      in   1       asynchronous, active-low reset
// - sess_start in   1       1-cycle pulse; opens a session
// - res_vld    in   1       result valid from the multiplier pipe
// - result     in   DATA_W  product from the multiplier pipe
// - pipe_done  in   1       1-cycle pulse; the multiplier stream has ended
// - out_vld    out  1       out_data valid
// - out_rdy    in   1       downstream accepts out_data
// - out_data   out  DATA_W  head-of-FIFO product
// - res_cnt    out  CNT_W   products accepted this session; saturates at all-ones
// - busy       out  1       high in COLLECT or DRAIN
// - sess_done  out  1       1-cycle pulse at the end of a session
// - ovf_err    out  1       sticky; a result was dropped because the FIFO was full
// BEHAVIOUR
// - Reset (reset==0, async): all outputs 0, FIFO empty, state IDLE.
// - FSM states:
//   - IDLE: sess_start -> COLLECT, clears res_cnt, ovf_err and acc_sum. res_vld and pipe_done ignored.
//   - COLLECT: res_vld pushes result. pipe_done -> DRAIN. sess_start ignored.
//   - DRAIN: no pushes (res_vld ignored). FIFO empty -> DONE.
//   - DONE: sess_done=1 for exactly one cycle -> IDLE.
// - Push and handshake:
//   - A push occurs when state==COLLECT && res_vld && (!full || pop).
//   - pop = out_vld && out_rdy.
// - Latency: a result pushed at edge N is visible on out_vld/out_data after edge N (registered), i.e. in cycle N+1 when the FIFO was empty.
// - out_data is held stable while out_vld && !out_rdy.
// - res_cnt increments on every push and saturates at 2^CNT_W-1.
// - Full FIFO with no pop: the result is dropped, ovf_err is set and res_cnt is not incremented.
// - Full FIFO with a pop in the same cycle: push and pop both occur; occupancy is unchanged.
// - Empty FIFO: out_vld=0; out_rdy has no effect.
// - res_vld with pipe_done in the same cycle: the result is pushed, then the FSM enters DRAIN.
// - pipe_done with an empty FIFO: COLLECT -> DRAIN -> DONE, so sess_done pulses 2 cycles after pipe_done.
// - Pointers are PTR_W+1 bits (PTR_W = log2 DEPTH); wrap-around uses the MSB for full/empty.
// - Reset asserted mid-session: the FIFO is flushed, no sess_done is issued, and the FSM returns to IDLE.
// CONFIGURATION
// - MUL_COLLECT_SUM_EN defined: adds output acc_sum[SUM_W-1:0].
//   - acc_sum adds zero-extended result on every push and wraps mod 2^SUM_W.
//   - acc_sum is cleared by reset and by sess_start in IDLE; it holds after sess_done until the next session.
// - MUL_COLLECT_SUM_EN undefined: port acc_sum is absent; no adder is built.
// TESTING
// - Basic stream: sess_start; 5 results 0x0C,0x31,0x00,0xE1,0x04 with out_rdy=1; pipe_done.
//   -> same 5 values out in order, 1-cycle latency, res_cnt=5, sess_done 1 cycle after the FIFO empties, ovf_err=0.
// - Backpressure: out_rdy=0, 8 pushes (DEPTH=8) then a 9th push.
//   -> 9th dropped, ovf_err=1, res_cnt=8; then out_rdy=1 -> 8 values out.
// - Full plus simultaneous pop: FIFO full, res_vld with out_rdy=1 in the same cycle.
//   -> push accepted, occupancy stays 8, ovf_err=0.
// - Idle filtering: res_vld=1 for 10 cycles in IDLE -> no out_vld, res_cnt=0.
//   Empty session: pipe_done right after sess_start -> sess_done 2 cycles later.
// - Reset mid-DRAIN with 3 entries queued: pull reset low for 1 cycle.
//   -> out_vld=0, busy=0, no sess_done, and the next session starts clean.
// - With MUL_COLLECT_SUM_EN: 200 pushes of 0xE1 (225) -> acc_sum=45000; next sess_start -> acc_sum=0.

Source files
------------

// File: rtl/mul_result_collector.sv
// ============================================================================
// Module   : mul_result_collector
// Brief    : Session-framed collector for the 4x4 multiplier result stream.
//            FIFO-buffered valid/ready output, product count, drop flag.
//            Optional accumulator output enabled by MUL_COLLECT_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_result_collector #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
`ifdef MUL_COLLECT_SUM_EN
   parameter int SUM_W  = 16,
`endif
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sess_start,
   input  logic              res_vld,
   input  logic [DATA_W-1:0] result,
   input  logic              pipe_done,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  res_cnt,
   output logic              busy,
   output logic              sess_done,
`ifdef MUL_COLLECT_SUM_EN
   output logic [SUM_W-1:0]  acc_sum,
`endif
   output logic              ovf_err
);

   localparam int                 c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_PTR_ONE = (c_PTR_W + 1)'(1);
   localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_busy;
   logic                r_sess_done;
   logic                r_ovf_err;
   logic [CNT_W-1:0]    r_res_cnt;
   logic [c_PTR_W:0]    r_wr_ptr;
   logic [c_PTR_W:0]    r_rd_ptr;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_open;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                    (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
   assign w_pop   = !w_empty && out_rdy;
   assign w_push  = (r_state == ST_COLLECT) && res_vld && (!w_full || w_pop);
   assign w_drop  = (r_state == ST_COLLECT) && res_vld && w_full && !w_pop;
   assign w_open  = (r_state == ST_IDLE) && sess_start;

   assign out_vld   = !w_empty;
   assign out_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];
   assign res_cnt   = r_res_cnt;
   assign busy      = r_busy;
   assign sess_done = r_sess_done;
   assign ovf_err   = r_ovf_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= result;
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_res_cnt <= '0;
         r_ovf_err <= 1'b0;
      end else if (w_open) begin
         r_res_cnt <= '0;
         r_ovf_err <= 1'b0;
      end else begin
         if (w_push && (r_res_cnt != c_CNT_MAX)) begin
            r_res_cnt <= r_res_cnt + c_CNT_ONE;
         end
         if (w_drop) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_sess_done <= 1'b0;
      end else begin
         r_sess_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sess_start) begin
                  r_state <= ST_COLLECT;
                  r_busy  <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (pipe_done) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_empty) begin
                  r_state     <= ST_DONE;
                  r_busy      <= 1'b0;
                  r_sess_done <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUL_COLLECT_SUM_EN
   logic [SUM_W-1:0] r_acc_sum;

   assign acc_sum = r_acc_sum;

   // Wraps modulo 2^SUM_W; holds after the session until the next sess_start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc_sum <= '0;
      end else if (w_open) begin
         r_acc_sum <= '0;
      end else if (w_push) begin
         r_acc_sum <= r_acc_sum + SUM_W'(result);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_result_collector.sv
// ============================================================================
// Module   : tb_mul_result_collector
// Brief    : Directed scoreboard bench for mul_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_result_collector;

   logic        clk;
   logic        reset;
   logic        sess_start;
   logic        res_vld;
   logic [7:0]  result;
   logic        pipe_done;
   logic        out_vld;
   logic        out_rdy;
   logic [7:0]  out_data;
   logic [15:0] res_cnt;
   logic        busy;
   logic        sess_done;
   logic        ovf_err;
`ifdef MUL_COLLECT_SUM_EN
   logic [15:0] acc_sum;
`endif

   int errors = 0;
   int checks = 0;
   int pops = 0;
   int done_cnt = 0;
   logic [7:0] sb [$];

   mul_result_collector dut (
      .clk        (clk),
      .reset      (reset),
      .sess_start (sess_start),
      .res_vld    (res_vld),
      .result     (result),
      .pipe_done  (pipe_done),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .res_cnt    (res_cnt),
      .busy       (busy),
      .sess_done  (sess_done),
`ifdef MUL_COLLECT_SUM_EN
      .acc_sum    (acc_sum),
`endif
      .ovf_err    (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sess();
      sess_start = 1'b1;
      tick();
      sess_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (sess_done) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
      tick();
   endtask

   // Scoreboard consumer: every accepted output beat must match the queue head.
   always @(negedge clk) begin
      logic [31:0] exp;
      if (reset && out_vld && out_rdy) begin
         exp = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
         chk("out_data_sb", 32'(out_data), exp);
         pops++;
      end
      if (sess_done) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] basic [5];
      int pops0;
      int done0;
      basic[0] = 8'h0C; basic[1] = 8'h31; basic[2] = 8'h00;
      basic[3] = 8'hE1; basic[4] = 8'h04;

      reset = 1'b0; sess_start = 1'b0; res_vld = 1'b0; result = '0;
      pipe_done = 1'b0; out_rdy = 1'b0;
      tick(); tick();
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sess_done", 32'(sess_done), 32'd0);
      chk("rst_ovf_err", 32'(ovf_err), 32'd0);
      chk("rst_res_cnt", 32'(res_cnt), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      reset = 1'b1;
      tick();

      // Idle filtering
      res_vld = 1'b1; result = 8'h55; out_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_out_vld", 32'(out_vld), 32'd0);
      end
      res_vld = 1'b0;
      chk("idle_res_cnt", 32'(res_cnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Empty session: sess_done two cycles after pipe_done
      start_sess();
      chk("empty_busy", 32'(busy), 32'd1);
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      chk("empty_done_early", 32'(sess_done), 32'd0);
      tick();
      chk("empty_done_pulse", 32'(sess_done), 32'd1);
      chk("empty_busy_done", 32'(busy), 32'd0);
      tick();
      chk("empty_done_1cyc", 32'(sess_done), 32'd0);

      // Basic stream with 1-cycle latency
      start_sess();
      for (int i = 0; i < 5; i++) begin
         res_vld = 1'b1; result = basic[i];
         sb.push_back(basic[i]);
         tick();
         chk("basic_lat_vld", 32'(out_vld), 32'd1);
         chk("basic_lat_data", 32'(out_data), 32'(basic[i]));
      end
      res_vld = 1'b0; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("basic_sess_done", 20);
      chk("basic_res_cnt", 32'(res_cnt), 32'd5);
      chk("basic_ovf_err", 32'(ovf_err), 32'd0);
      chk("basic_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure and overflow drop
      out_rdy = 1'b0;
      start_sess();
      chk("bp_cnt_clear", 32'(res_cnt), 32'd0);
      for (int i = 0; i < 8; i++) begin
         v = 8'(i * 37 + 5);
         res_vld = 1'b1; result = v;
         sb.push_back(v);
         tick();
      end
      result = 8'hAA;
      tick();
      res_vld = 1'b0;
      chk("bp_ovf_err", 32'(ovf_err), 32'd1);
      chk("bp_res_cnt", 32'(res_cnt), 32'd8);
      chk("bp_hold_data", 32'(out_data), 32'd5);
      pops0 = pops;
      out_rdy = 1'b1; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("bp_sess_done", 30);
      chk("bp_pop_count", 32'(pops - pops0), 32'd8);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Full FIFO with simultaneous push and pop
      out_rdy = 1'b0;
      start_sess();
      chk("fp_ovf_clear", 32'(ovf_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         v = 8'(8'h80 + i);
         res_vld = 1'b1; result = v;
         sb.push_back(v);
         tick();
      end
      result = 8'h77; out_rdy = 1'b1;
      sb.push_back(8'h77);
      tick();
      chk("fp_ovf_err", 32'(ovf_err), 32'd0);
      chk("fp_res_cnt", 32'(res_cnt), 32'd9);
      chk("fp_head", 32'(out_data), 32'h81);
      out_rdy = 1'b0; result = 8'h99;
      tick();
      res_vld = 1'b0;
      chk("fp_still_full_drop", 32'(ovf_err), 32'd1);
      chk("fp_cnt_after_drop", 32'(res_cnt), 32'd9);
      out_rdy = 1'b1; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("fp_sess_done", 30);
      chk("fp_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during DRAIN with 3 entries queued
      out_rdy = 1'b0;
      start_sess();
      for (int i = 0; i < 3; i++) begin
         res_vld = 1'b1; result = 8'(8'h40 + i);
         tick();
      end
      res_vld = 1'b0; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      chk("rd_busy_drain", 32'(busy), 32'd1);
      done0 = done_cnt;
      reset = 1'b0;
      #1;
      chk("rd_out_vld", 32'(out_vld), 32'd0);
      chk("rd_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("rd_no_sess_done", 32'(done_cnt - done0), 32'd0);
      chk("rd_out_vld_after", 32'(out_vld), 32'd0);
      start_sess();
      chk("rd_clean_cnt", 32'(res_cnt), 32'd0);
      chk("rd_clean_ovf", 32'(ovf_err), 32'd0);
      out_rdy = 1'b1; res_vld = 1'b1; result = 8'h3C;
      sb.push_back(8'h3C);
      tick();
      res_vld = 1'b0; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("rd_next_sess_done", 20);
      chk("rd_next_cnt", 32'(res_cnt), 32'd1);
      chk("rd_sb_empty", 32'(sb.size()), 32'd0);

`ifdef MUL_COLLECT_SUM_EN
      // Accumulator: 200 x 225 = 45000
      start_sess();
      chk("sum_clear0", 32'(acc_sum), 32'd0);
      for (int i = 0; i < 200; i++) begin
         res_vld = 1'b1; result = 8'hE1;
         sb.push_back(8'hE1);
         tick();
      end
      res_vld = 1'b0; pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("sum_sess_done", 20);
      chk("sum_value", 32'(acc_sum), 32'd45000);
      chk("sum_cnt", 32'(res_cnt), 32'd200);
      tick(); tick();
      chk("sum_hold", 32'(acc_sum), 32'd45000);
      start_sess();
      chk("sum_cleared", 32'(acc_sum), 32'd0);
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      wait_done("sum_empty_done", 10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
